// File: rtl/tetris_input_ctrl.sv
// N-channel game-input conditioner: merge, synchronise and debounce each channel,
// then generate press pulses with delayed auto-repeat (DAS/ARR).
module tetris_input_ctrl #(
  parameter int unsigned      N_CH         = 4,
  parameter int unsigned      CNT_W        = 24,
  parameter int unsigned      DEBOUNCE_CYC = 300000,
  parameter int unsigned      DAS_CYC      = 6000000,
  parameter int unsigned      ARR_CYC      = 1500000,
  parameter logic [N_CH-1:0]  REPEAT_MASK  = 4'b1110
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic [N_CH-1:0] btn_a,
  input  logic [N_CH-1:0] btn_b,
  input  logic            enable,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] level,
  output logic            any_press
);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_HELD
  } state_t;

  localparam longint unsigned CYC_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam bit PARAM_OK =
    (DEBOUNCE_CYC >= 1) && (64'(DEBOUNCE_CYC) <= CYC_MAX) &&
    (DAS_CYC      >= 1) && (64'(DAS_CYC)      <= CYC_MAX) &&
    (ARR_CYC      >= 1) && (64'(ARR_CYC)      <= CYC_MAX);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYC - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYC - 1);

  logic [N_CH-1:0]  r_sync1;
  logic [N_CH-1:0]  r_sync2;
  logic [N_CH-1:0]  r_db;
  logic [N_CH-1:0]  r_lvl;
  logic [N_CH-1:0]  r_pulse;
  logic             r_any;
  logic [1:0]       r_warm;
  logic [CNT_W-1:0] r_db_cnt    [N_CH];
  logic [CNT_W-1:0] r_timer     [N_CH];
  state_t           r_state     [N_CH];

  logic [CNT_W-1:0] w_timer_nxt [N_CH];
  state_t           w_state_nxt [N_CH];
  logic [N_CH-1:0]  w_pulse_nxt;
  logic [N_CH-1:0]  w_rise;
  logic [N_CH-1:0]  w_fall;
  logic [N_CH-1:0]  w_quiet;

  always_ff @(posedge clk) begin : p_param_chk
    assert (PARAM_OK) else $error("tetris_input_ctrl: *_CYC parameter outside 1..2^CNT_W-1");
  end

  // Input path: merge, 2-flop synchroniser, debounce counter.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_warm  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= btn_a | btn_b;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DEB_LAST) begin
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_rise = r_db & ~r_lvl;
  assign w_fall = ~r_db & r_lvl;
  // Leaving LOCKED also waits for the synchroniser to refill after reset and to
  // read low, so a button held through reset can never look released.
  assign w_quiet = ~(r_db | r_sync1 | r_sync2) & {N_CH{r_warm[1]}};

  always_comb begin
    w_pulse_nxt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_timer_nxt[i] = r_timer[i];
      if (!enable) begin
        w_state_nxt[i] = S_LOCKED;
        w_timer_nxt[i] = '0;
      end else begin
        case (r_state[i])
          S_LOCKED: begin
            if (w_quiet[i]) w_state_nxt[i] = S_IDLE;
          end
          S_IDLE: begin
            if (w_rise[i]) begin
              w_state_nxt[i] = S_DELAY;
              w_timer_nxt[i] = '0;
              w_pulse_nxt[i] = 1'b1;
            end
          end
          S_DELAY: begin
            if (w_fall[i]) begin
              w_state_nxt[i] = S_IDLE;
            end else if (r_timer[i] == DAS_LAST) begin
              w_timer_nxt[i] = '0;
              if (REPEAT_MASK[i]) begin
                w_state_nxt[i] = S_REPEAT;
                w_pulse_nxt[i] = 1'b1;
              end else begin
                w_state_nxt[i] = S_HELD;
              end
            end else begin
              w_timer_nxt[i] = r_timer[i] + 1'b1;
            end
          end
          S_REPEAT: begin
            if (w_fall[i]) begin
              w_state_nxt[i] = S_IDLE;
            end else if (r_timer[i] == ARR_LAST) begin
              w_timer_nxt[i] = '0;
              w_pulse_nxt[i] = 1'b1;
            end else begin
              w_timer_nxt[i] = r_timer[i] + 1'b1;
            end
          end
          S_HELD: begin
            if (w_fall[i]) w_state_nxt[i] = S_IDLE;
          end
          default: begin
            w_state_nxt[i] = S_LOCKED;
            w_timer_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_lvl   <= '0;
      r_pulse <= '0;
      r_any   <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_state[i] <= S_LOCKED;
        r_timer[i] <= '0;
      end
    end else begin
      r_lvl   <= r_db;
      r_pulse <= w_pulse_nxt;
      r_any   <= |w_pulse_nxt;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_timer[i] <= w_timer_nxt[i];
      end
    end
  end

  assign pulse     = r_pulse;
  assign level     = r_lvl;
  assign any_press = r_any;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: history-window reference model checked every cycle,
// plus literal expectations for the directed press scenarios.
module tb_tetris_input_ctrl;

  localparam int MAXE = 4096;
  localparam int DEB  = 4;
  localparam int DAS  = 10;
  localparam int ARR  = 3;
  localparam logic [3:0] MASK = 4'b1110;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       enable;
  logic [3:0] btn_a;
  logic [3:0] btn_b;
  logic [3:0] pulse;
  logic [3:0] level;
  logic       any_press;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [3:0] s_hist [MAXE];
  logic [3:0] l_hist [MAXE];
  logic [3:0] dut_p  [MAXE];
  logic [3:0] dut_l  [MAXE];
  logic       dut_any[MAXE];

  tetris_input_ctrl #(
    .N_CH(4),
    .CNT_W(8),
    .DEBOUNCE_CYC(DEB),
    .DAS_CYC(DAS),
    .ARR_CYC(ARR),
    .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .btn_a(btn_a),
    .btn_b(btn_b),
    .enable(enable),
    .pulse(pulse),
    .level(level),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic get_s(input int idx, input int c);
    if (idx < 0) return 1'b0;
    return s_hist[idx][c];
  endfunction

  function automatic int cnt_p(input int c, input int a, input int b);
    int k = 0;
    for (int i = a; i <= b; i++) if (dut_p[i][c]) k++;
    return k;
  endfunction

  function automatic int cnt_l(input int c, input int a, input int b);
    int k = 0;
    for (int i = a; i <= b; i++) if (dut_l[i][c]) k++;
    return k;
  endfunction

  // Reference model and per-cycle compare
  initial begin : monitor
    logic [3:0] raw, olvl, pe, locked, olvl_prev, mask_v;
    logic       en, rs, lp, tog;
    int         n, age, last_rst;
    int         pstart [4];
    mask_v    = MASK;
    last_rst  = -1000;
    locked    = '1;
    olvl_prev = '0;
    for (int c = 0; c < 4; c++) pstart[c] = -1;
    forever begin
      @(posedge clk);
      n = cyc;
      cyc++;
      raw = btn_a | btn_b;
      en  = enable;
      rs  = !clr_n;
      pe  = '0;
      if (rs) begin
        s_hist[n] = '0;
        l_hist[n] = '0;
        olvl      = '0;
        locked    = '1;
        last_rst  = n;
        for (int c = 0; c < 4; c++) pstart[c] = -1;
      end else begin
        s_hist[n] = raw;
        olvl = (n > 0) ? l_hist[n-1] : 4'b0000;
        for (int c = 0; c < 4; c++) begin
          // level flips once the synchronised raw has disagreed for DEB samples in a row
          lp  = (n > 0) ? l_hist[n-1][c] : 1'b0;
          tog = (n - DEB - 1 > last_rst);
          for (int j = 0; j < DEB; j++)
            if (get_s(n - 2 - j, c) == lp) tog = 1'b0;
          l_hist[n][c] = tog ? ~lp : lp;

          if (en && !locked[c]) begin
            if (olvl[c] && !olvl_prev[c]) pstart[c] = n;
            if (olvl[c] && pstart[c] >= 0) begin
              age = n - pstart[c];
              if (age == 0 || (mask_v[c] && age >= DAS && (age - DAS) % ARR == 0))
                pe[c] = 1'b1;
            end
          end
          if (!olvl[c]) pstart[c] = -1;
          if (!en) begin
            locked[c] = 1'b1;
            pstart[c] = -1;
          end else if (locked[c] && n >= last_rst + 3 && !lp &&
                       !get_s(n - 1, c) && !get_s(n - 2, c)) begin
            locked[c] = 1'b0;
          end
        end
      end
      olvl_prev = olvl;
      #1;
      chk("pulse", int'(pulse), int'(pe));
      chk("level", int'(level), int'(olvl));
      chk("any_press", int'(any_press), int'(|pe));
      dut_p[n]   = pulse;
      dut_l[n]   = level;
      dut_any[n] = any_press;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin : stim
    int k, k2;
    btn_a  = '0;
    btn_b  = '0;
    enable = 1'b0;
    clr_n  = 1'b0;

    // Button held through reset: no pulse until released and pressed again
    @(negedge clk);
    btn_a[0] = 1'b1;
    enable   = 1'b1;
    wait_neg(4);
    clr_n = 1'b1;
    wait_neg(20);
    btn_a[0] = 1'b0;
    wait_neg(15);
    k = cyc;
    btn_a[0] = 1'b1;
    wait_neg(8);
    btn_a[0] = 1'b0;
    wait_neg(15);
    chk("held_through_reset_no_pulse", cnt_p(0, 0, k + 5), 0);
    chk("first_pulse_at_k6", int'(dut_p[k+6][0]), 1);
    chk("pulse_one_cycle", int'(dut_p[k+7][0]), 0);
    chk("level_high_at_k6", int'(dut_l[k+6][0]), 1);
    chk("level_low_at_k5", int'(dut_l[k+5][0]), 0);
    chk("single_press_count", cnt_p(0, k, cyc - 1), 1);

    // 3-cycle glitch on btn_b[2]
    k = cyc;
    btn_b[2] = 1'b1;
    wait_neg(3);
    btn_b[2] = 1'b0;
    wait_neg(15);
    chk("glitch_level", cnt_l(2, k, cyc - 1), 0);
    chk("glitch_pulse", cnt_p(2, k, cyc - 1), 0);

    // Auto-repeat on channel 2, level high for 30 cycles
    k = cyc;
    btn_a[2] = 1'b1;
    wait_neg(30);
    btn_a[2] = 1'b0;
    wait_neg(15);
    begin
      int offs [8] = '{0, 10, 13, 16, 19, 22, 25, 28};
      for (int i = 0; i < 8; i++) chk("repeat_offset", int'(dut_p[k+6+offs[i]][2]), 1);
    end
    chk("repeat_count", cnt_p(2, k, cyc - 1), 8);
    chk("release_level_high_k35", int'(dut_l[k+35][2]), 1);
    chk("release_level_low_k36", int'(dut_l[k+36][2]), 0);

    // Non-repeating channel 0 held 40 cycles
    k = cyc;
    btn_b[0] = 1'b1;
    wait_neg(40);
    btn_b[0] = 1'b0;
    wait_neg(15);
    chk("norepeat_count", cnt_p(0, k, cyc - 1), 1);

    // Simultaneous presses on channels 1 and 3
    k = cyc;
    btn_a[1] = 1'b1;
    btn_b[3] = 1'b1;
    wait_neg(6);
    btn_a[1] = 1'b0;
    btn_b[3] = 1'b0;
    wait_neg(15);
    chk("simul_pulse_vec", int'(dut_p[k+6]), 4'b1010);
    chk("simul_any_press", int'(dut_any[k+6]), 1);

    // Overlapping btn_a[1]/btn_b[1]: merged raw high 22 cycles
    k = cyc;
    btn_a[1] = 1'b1;
    wait_neg(2);
    btn_b[1] = 1'b1;
    wait_neg(18);
    btn_a[1] = 1'b0;
    wait_neg(2);
    btn_b[1] = 1'b0;
    wait_neg(15);
    chk("dual_source_count", cnt_p(1, k, cyc - 1), 5);

    // Enable dropped during REPEAT on channel 3
    k = cyc;
    btn_a[3] = 1'b1;
    wait_neg(21);
    enable = 1'b0;
    wait_neg(5);
    enable = 1'b1;
    wait_neg(20);
    btn_a[3] = 1'b0;
    wait_neg(15);
    k2 = cyc;
    btn_a[3] = 1'b1;
    wait_neg(8);
    btn_a[3] = 1'b0;
    wait_neg(15);
    chk("pause_pulses_before", cnt_p(3, k, k2 - 1), 3);
    chk("pause_gated_pulse", int'(dut_p[k+22][3]), 0);
    chk("pause_repress_pulse", int'(dut_p[k2+6][3]), 1);
    chk("pause_repress_count", cnt_p(3, k2, cyc - 1), 1);

    // Reset mid-hold on channel 1
    k = cyc;
    btn_a[1] = 1'b1;
    wait_neg(10);
    clr_n = 1'b0;
    wait_neg(2);
    clr_n = 1'b1;
    wait_neg(20);
    btn_a[1] = 1'b0;
    wait_neg(15);
    k2 = cyc;
    btn_a[1] = 1'b1;
    wait_neg(8);
    btn_a[1] = 1'b0;
    wait_neg(15);
    chk("midreset_first_pulse", cnt_p(1, k, k + 9), 1);
    chk("midreset_locked", cnt_p(1, k + 10, k2 + 5), 0);
    chk("midreset_repress", int'(dut_p[k2+6][1]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
